// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD line/frame timing generator.
package lcd_pkg;

  localparam int unsigned PIX_PER_PPL = 16;
  localparam int unsigned PH_W        = 11;  // horizontal phase counter width
  localparam int unsigned LN_W        = 10;  // vertical line counter width

  typedef enum logic [2:0] {H_IDLE, H_SYNC, H_BP, H_ACT, H_FP} h_state_e;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} v_state_e;

  typedef struct packed {
    logic [7:0] hsw;
    logic [7:0] hbp;
    logic [7:0] hfp;
    logic [5:0] ppl;
    logic [5:0] vsw;
    logic [7:0] vbp;
    logic [7:0] vfp;
    logic [9:0] lpp;
    logic       ihs;
    logic       ivs;
    logic       ioe;
  } timing_t;

  // Reload value for H_ACT: 16*(ppl+1)-1, at most 1023.
  function automatic logic [PH_W-1:0] act_len_m1(input logic [5:0] ppl);
    logic [PH_W-1:0] n;
    n = PH_W'(PIX_PER_PPL) * (PH_W'(ppl) + PH_W'(1));
    return n - PH_W'(1);
  endfunction

endpackage

// File: rtl/lcd_phase_cnt.sv
// Loadable down-counter with decrement enable and zero flag; one per timing axis.
module lcd_phase_cnt #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD line/frame timing generator: horizontal/vertical phase FSMs, shadowed timing,
// registered sync/enable outputs and active-area pixel requests.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          lcd_en,
  input  logic          pix_en,
  input  logic [7:0]    hsw,
  input  logic [7:0]    hbp,
  input  logic [7:0]    hfp,
  input  logic [5:0]    ppl,
  input  logic [5:0]    vsw,
  input  logic [7:0]    vbp,
  input  logic [7:0]    vfp,
  input  logic [9:0]    lpp,
  input  logic          ihs,
  input  logic          ivs,
  input  logic          ioe,
  output logic          LCDLP,
  output logic          LCDFP,
  output logic          LCDENA,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_done
);

  timing_t   sh_q, sh_in, tim;
  h_state_e  h_q, h_d;
  v_state_e  v_q, v_d;
  logic      step, start, eol, fdone, act;
  logic      h_zero, h_load, h_dec, v_zero, v_load, v_dec;
  logic [PH_W-1:0] h_val;
  logic [LN_W-1:0] v_val;
  logic [XW-1:0]   col_q, pix_x_q;
  logic [YW-1:0]   pix_y_q;
  logic      lp_q, fp_q, ena_q, req_q, fd_q;

  assign sh_in = {hsw, hbp, hfp, ppl, vsw, vbp, vfp, lpp, ihs, ivs, ioe};

  always_comb begin
    step  = lcd_en && pix_en;
    start = step && (h_q == H_IDLE);
    eol   = step && (h_q == H_FP) && h_zero;
    fdone = eol && (v_q == V_FP) && v_zero;
    act   = step && (h_q == H_ACT) && (v_q == V_ACT);
    // Phases entered on a capture cycle already use the newly captured timing.
    tim   = (start || fdone) ? sh_in : sh_q;

    h_d    = h_q;
    h_load = 1'b0;
    h_dec  = 1'b0;
    h_val  = '0;
    if (!lcd_en) begin
      h_d = H_IDLE;
    end else if (step) begin
      if ((h_q == H_IDLE) || h_zero) begin
        h_load = 1'b1;
        case (h_q)
          H_SYNC: begin h_d = H_BP;   h_val = PH_W'(tim.hbp);     end
          H_BP:   begin h_d = H_ACT;  h_val = act_len_m1(tim.ppl); end
          H_ACT:  begin h_d = H_FP;   h_val = PH_W'(tim.hfp);     end
          default: begin h_d = H_SYNC; h_val = PH_W'(tim.hsw);    end
        endcase
      end else begin
        h_dec = 1'b1;
      end
    end

    v_d    = v_q;
    v_load = 1'b0;
    v_dec  = 1'b0;
    v_val  = '0;
    if (!lcd_en) begin
      v_d = V_SYNC;
    end else if (start) begin
      v_d    = V_SYNC;
      v_load = 1'b1;
      v_val  = LN_W'(tim.vsw);
    end else if (eol) begin
      if (v_zero) begin
        v_load = 1'b1;
        case (v_q)
          V_SYNC: begin v_d = V_BP;   v_val = LN_W'(tim.vbp); end
          V_BP:   begin v_d = V_ACT;  v_val = LN_W'(tim.lpp); end
          V_ACT:  begin v_d = V_FP;   v_val = LN_W'(tim.vfp); end
          default: begin v_d = V_SYNC; v_val = LN_W'(tim.vsw); end
        endcase
      end else begin
        v_dec = 1'b1;
      end
    end
  end

  lcd_phase_cnt #(.W(PH_W)) u_h_cnt (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .clr      (!lcd_en),
    .load     (h_load),
    .load_val (h_val),
    .dec      (h_dec),
    .zero     (h_zero)
  );

  lcd_phase_cnt #(.W(LN_W)) u_v_cnt (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .clr      (!lcd_en),
    .load     (v_load),
    .load_val (v_val),
    .dec      (v_dec),
    .zero     (v_zero)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      h_q     <= H_IDLE;
      v_q     <= V_SYNC;
      sh_q    <= '0;
      lp_q    <= 1'b0;
      fp_q    <= 1'b0;
      ena_q   <= 1'b0;
      req_q   <= 1'b0;
      fd_q    <= 1'b0;
      col_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      sh_q  <= tim;
      lp_q  <= (h_d == H_SYNC) ^ tim.ihs;
      fp_q  <= ((h_d != H_IDLE) && (v_d == V_SYNC)) ^ tim.ivs;
      ena_q <= ((h_d == H_ACT) && (v_d == V_ACT)) ^ tim.ioe;
      req_q <= act;
      fd_q  <= fdone;
      if (!lcd_en) begin
        col_q   <= '0;
        pix_x_q <= '0;
        pix_y_q <= '0;
      end else begin
        if (act) begin
          pix_x_q <= col_q;
          col_q   <= col_q + XW'(1);
        end
        if (eol) col_q <= '0;
        if (eol && (v_q == V_ACT)) pix_y_q <= pix_y_q + YW'(1);
        if (fdone) pix_y_q <= '0;
      end
    end
  end

  assign LCDLP      = lp_q;
  assign LCDFP      = fp_q;
  assign LCDENA     = ena_q;
  assign pix_req    = req_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = fd_q;

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Line/frame timing generator for the LCD controller, directly downstream of the pixel-clock divider. Consumes the one-HCLK-wide pixel-clock strobe and the LCD_TIMH/LCD_TIMV/LCD_POL fields, and walks horizontal and vertical timing state machines. Produces registered LCDLP (line sync), LCDFP (frame sync), LCDENA (data enable), and a pixel-request strobe to the pixel FIFO. Also reports active-area coordinates and end-of-frame to the DMA/interrupt logic.

## Interface
Parameters:
- XW, 10, active pixel-column counter width
- YW, 10, active line counter width

Ports:
- HCLK  in  1  system clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- lcd_en  in  1  LCD_CTRL.LcdEn; 0 forces IDLE
- pix_en  in  1  one-HCLK strobe per LCDDCLK period from the clock divider
- hsw, hbp, hfp  in  8 each  LCD_TIMH fields; phase length = field+1 pixel clocks
- ppl  in  6  LCD_TIMH.PPL; active pixels = 16*(ppl+1)
- vsw  in  6  LCD_TIMV.VSW; sync lines = vsw+1
- vbp, vfp  in  8 each  LCD_TIMV porches; lines = field+1
- lpp  in  10  LCD_TIMV.LPP; active lines = lpp+1
- ihs, ivs, ioe  in  1 each  LCD_POL inversion of LCDLP/LCDFP/LCDENA
- LCDLP  out  1  line sync
- LCDFP  out  1  frame sync
- LCDENA  out  1  data enable
- pix_req  out  1  one-HCLK strobe per active pixel
- pix_x  out  XW  active column, 0-based
- pix_y  out  YW  active line, 0-based
- frame_done  out  1  one-HCLK pulse at the end of the last VFP line

## Operation
- Shadow registers: all timing and polarity inputs are captured on IDLE→run and at every frame_done. Mid-frame register writes take effect from the next frame.
- Horizontal FSM: H_IDLE → H_SYNC → H_BP → H_ACT → H_FP → H_SYNC … A phase counter decrements only on pix_en. On reaching 0 with pix_en, the FSM moves to the next phase and reloads the counter.
- End-of-line (eol): the pix_en that terminates H_FP.
- Vertical FSM: V_SYNC → V_BP → V_ACT → V_FP → V_SYNC. The line counter advances only on eol. frame_done fires on the eol that terminates V_FP.
- Active levels (before inversion):
  - LCDLP = 1 in H_SYNC.
  - LCDFP = 1 for whole lines in V_SYNC.
  - LCDENA = 1 in H_ACT∧V_ACT.
- pix_req fires on each pix_en in H_ACT∧V_ACT.
- pix_x increments per active pixel and clears at eol. pix_y increments per active line and clears at frame_done.
- Polarity: each output is XOR'd with its shadowed ihs/ivs/ioe.
- Start from IDLE: when lcd_en rises, the first pix_en enters H_SYNC/V_SYNC at line 0.
- lcd_en low: next HCLK goes to IDLE; counters clear; outputs go to inactive level (polarity-applied); pix_req=0. This holds even mid-line.
- Arithmetic: 16*(ppl+1) is computed at 11 bits (max 1024). Phase counters are 11 bits; line counter is 10 bits; no wrap inside a phase.

## Timing
- Reset: both FSMs IDLE, counters 0. LCDLP=LCDFP=LCDENA=0, pix_req=0, pix_x=pix_y=0, frame_done=0. Shadow registers are 0, so polarity is non-inverted.
- All outputs are registered. Every transition appears one HCLK after the pix_en cycle that causes it.
- pix_en held high every cycle is legal (CLKDIV=0) and gives one phase step per HCLK.
- pix_en while lcd_en=0 is ignored.
- pix_en coincident with the lcd_en fall: lcd_en wins, and the FSM goes to IDLE.
- Minimum line = 1+1+16+1 = 19 pixel clocks. Minimum frame = 4 lines.
- Async HRESETn assertion mid-frame clears state immediately. Release is synchronized by the existing reset logic.

## Structure
- Package lcd_pkg holds:
  - h_state_e {H_IDLE,H_SYNC,H_BP,H_ACT,H_FP}
  - v_state_e {V_SYNC,V_BP,V_ACT,V_FP}
  - a timing shadow struct
  - localparam PIX_PER_PPL=16
- One sub-module, lcd_phase_cnt: a loadable down-counter with an enable and a zero flag. It is instantiated twice (horizontal and vertical).
- Polarity XOR and output registers stay in the top module.

## Test plan
- Reset: HRESETn low mid-line → all outputs 0 within the same cycle; restart after release begins at H_SYNC line 0.
- Minimal timing: pix_en=1 constant, all fields 0 → LCDLP high 1 HCLK, LCDENA high 16 HCLK/line, 19-HCLK line, frame_done every 76 HCLK.
- Nominal: hsw=3, hbp=7, ppl=1, hfp=4, vsw=1, vbp=2, lpp=3, vfp=1, pix_en every 4 HCLK → 4/8/32/5 pixel-clock phases; 4 active lines; 32 pix_req/line; pix_x 0..31; pix_y 0..3.
- Mid-frame write of ppl 1→3 → current frame keeps 32 pixels/line; next frame 64.
- Polarity: ihs=ivs=ioe=1 → LCDLP/LCDFP/LCDENA idle high and pulse low, with identical timing.
- lcd_en dropped in H_ACT → next HCLK: pix_req=0, outputs inactive; re-enable restarts at line 0 with no stale pix_x.
